// File: rtl/ifetch_bridge.sv
// Instruction fetch bridge: a two-entry buffer (demand D, prefetch P) between the
// CPU fetch port and a request/acknowledge memory, with next-line prefetch and a request timeout.
module ifetch_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DFETCH, PFETCH} state_e;

    state_e        state_q;
    logic          dValid_q, pValid_q;
    logic [29:0]   dTag_q, pTag_q;
    logic [31:0]   dData_q, pData_q;
    logic          memReq_q;
    logic [31:0]   memAddr_q;
    logic [CW-1:0] toCnt_q;
    logic          err_q;

    logic [29:0] cpuTag, nextTag, fetchTag;
    logic        dHit, pHit, pHoldsNext;
    logic        unusedBits;

    assign unusedBits = ^{RST_ADDR, rom_addr_i[1:0]};

    assign cpuTag   = rom_addr_i[31:2];
    assign nextTag  = cpuTag + 30'd1;
    assign fetchTag = memAddr_q[31:2];

    assign dHit = rom_ce_i && dValid_q && (dTag_q == cpuTag);
    assign pHit = rom_ce_i && !dHit && pValid_q && (pTag_q == cpuTag);

    // P as it will look after a P hit moves its line into D
    assign pHoldsNext = pValid_q && !pHit && (pTag_q == nextTag);

    always_comb begin
        rom_data_o  = '0;
        stall_req_o = 1'b0;
        if (rst_n && rom_ce_i) begin
            if (dHit) begin
                rom_data_o = dData_q;
            end else if (pHit) begin
                rom_data_o = pData_q;
            end else begin
                stall_req_o = 1'b1;
            end
        end
    end

    // Fetch data written at an ack overrides the P-to-D move made at the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dValid_q  <= 1'b0;
            pValid_q  <= 1'b0;
            dTag_q    <= '0;
            pTag_q    <= '0;
            dData_q   <= '0;
            pData_q   <= '0;
            memReq_q  <= 1'b0;
            memAddr_q <= '0;
            toCnt_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (pHit) begin
                dValid_q <= 1'b1;
                dTag_q   <= pTag_q;
                dData_q  <= pData_q;
                pValid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    toCnt_q <= '0;
                    if (rom_ce_i) begin
                        if (!dHit && !pHit) begin
                            state_q   <= DFETCH;
                            memReq_q  <= 1'b1;
                            memAddr_q <= {cpuTag, 2'b00};
                        end else if (!pHoldsNext) begin
                            state_q   <= PFETCH;
                            memReq_q  <= 1'b1;
                            memAddr_q <= {nextTag, 2'b00};
                        end
                    end
                end
                DFETCH, PFETCH: begin
                    if (mem_ack_i) begin
                        toCnt_q <= '0;
                        if (state_q == DFETCH || cpuTag == fetchTag) begin
                            dValid_q <= 1'b1;
                            dTag_q   <= fetchTag;
                            dData_q  <= mem_rdata_i;
                        end else begin
                            pValid_q <= 1'b1;
                            pTag_q   <= fetchTag;
                            pData_q  <= mem_rdata_i;
                        end
                        if (state_q == DFETCH && rom_ce_i) begin
                            state_q   <= PFETCH;
                            memAddr_q <= {fetchTag + 30'd1, 2'b00};
                        end else begin
                            state_q  <= IDLE;
                            memReq_q <= 1'b0;
                        end
                    end else if (toCnt_q == CNT_LAST) begin
                        err_q    <= 1'b1;
                        memReq_q <= 1'b0;
                        toCnt_q  <= '0;
                        state_q  <= IDLE;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o  = memReq_q;
    assign mem_addr_o = memAddr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ifetch_bridge.sv
// Self-checking bench for ifetch_bridge: directed scenarios with literal expectations,
// then randomized CPU/memory traffic compared every cycle against a buffer-level model.
module tb_ifetch_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int   tests;
    int   fails;
    logic lastStall;

    ifetch_bridge #(.TIMEOUT(TO), .RST_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .stall_req_o(stall_req_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: every word address holds a fixed value, 0x100 holds the cold-miss instruction
    function automatic logic [31:0] memWord(input logic [29:0] tag);
        if (tag == 30'h40) return 32'h0050_0093;
        return ({2'b00, tag} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct packed {
        logic        v;
        logic [29:0] tag;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        entry_t      d;
        entry_t      p;
        logic        busy;
        logic        demand;
        logic        err;
        logic [29:0] tag;
        logic [7:0]  waited;
    } model_t;

    model_t mState;

    // One clock of the bridge described as buffer/transfer rules
    function automatic model_t modelNext(input model_t m, input logic ce, input logic [29:0] t,
                                         input logic ack);
        model_t n;
        logic   dh, ph;
        entry_t got;
        n  = m;
        dh = ce && m.d.v && (m.d.tag == t);
        ph = ce && !dh && m.p.v && (m.p.tag == t);
        if (ph) begin
            n.d   = m.p;
            n.p.v = 1'b0;
        end
        if (!m.busy) begin
            if (ce && !dh && !ph) begin
                n.busy = 1'b1; n.demand = 1'b1; n.tag = t; n.waited = '0;
            end else if (ce && !(n.p.v && n.p.tag == t + 30'd1)) begin
                n.busy = 1'b1; n.demand = 1'b0; n.tag = t + 30'd1; n.waited = '0;
            end
        end else if (ack) begin
            got.v    = 1'b1;
            got.tag  = m.tag;
            got.data = memWord(m.tag);
            if (m.demand || t == m.tag) n.d = got;
            else                        n.p = got;
            if (m.demand && ce) begin
                n.demand = 1'b0; n.tag = m.tag + 30'd1; n.waited = '0;
            end else begin
                n.busy = 1'b0;
            end
        end else begin
            n.waited = m.waited + 8'd1;
            if (n.waited == 8'(TO)) begin
                n.err  = 1'b1;
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mState <= '0;
        else        mState <= modelNext(mState, rom_ce_i, rom_addr_i[31:2], mem_ack_i);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compareModel();
        logic        dh, ph, eStall;
        logic [31:0] eData;
        logic [29:0] t;
        t      = rom_addr_i[31:2];
        eData  = '0;
        eStall = 1'b0;
        dh = rom_ce_i && mState.d.v && (mState.d.tag == t);
        ph = rom_ce_i && !dh && mState.p.v && (mState.p.tag == t);
        if (rst_n && rom_ce_i) begin
            if (dh)      eData  = mState.d.data;
            else if (ph) eData  = mState.p.data;
            else         eStall = 1'b1;
        end
        checkOutput("romData", rom_data_o, eData);
        checkOutput("stall", {31'd0, stall_req_o}, {31'd0, eStall});
        checkOutput("memReq", {31'd0, mem_req_o}, {31'd0, mState.busy});
        if (mState.busy)  checkOutput("memAddr", mem_addr_o, {mState.tag, 2'b00});
        else if (!rst_n)  checkOutput("memAddrRst", mem_addr_o, 32'h0);
        checkOutput("err", {31'd0, err_o}, {31'd0, mState.err});
        lastStall = eStall;
    endtask

    task automatic applyStimulus(input logic ce, input logic [31:0] addr, input logic ack);
        @(posedge clk);
        #1;
        rom_ce_i    = ce;
        rom_addr_i  = addr;
        mem_ack_i   = ack;
        mem_rdata_i = memWord(mem_addr_o[31:2]);
        @(negedge clk);
        compareModel();
    endtask

    // Asserts reset between clock edges, spends one cycle in reset, releases mid-cycle
    task automatic pulseReset(input logic [31:0] addr);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncReqDrop", {31'd0, mem_req_o}, 32'h0);
        checkOutput("asyncAddrClr", mem_addr_o, 32'h0);
        checkOutput("asyncStallLow", {31'd0, stall_req_o}, 32'h0);
        applyStimulus(1'b1, addr, 1'b1);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int          cnt;
        logic [31:0] pc;
        logic        ce, ack;
        int          r;

        tests = 0; fails = 0; lastStall = 1'b0;
        rst_n = 1'b0; rom_ce_i = 1'b0; rom_addr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        applyStimulus(1'b1, 32'h100, 1'b1);
        checkOutput("rstStall", {31'd0, stall_req_o}, 32'h0);
        checkOutput("rstData", rom_data_o, 32'h0);
        checkOutput("rstReq", {31'd0, mem_req_o}, 32'h0);
        checkOutput("rstAddr", mem_addr_o, 32'h0);
        checkOutput("rstErr", {31'd0, err_o}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h100, (i == 2));
            cnt += int'(stall_req_o);
        end
        checkOutput("coldStallCycles", 32'(cnt), 32'd3);
        applyStimulus(1'b1, 32'h100, 1'b0);
        checkOutput("coldData", rom_data_o, 32'h0050_0093);
        checkOutput("coldStall", {31'd0, stall_req_o}, 32'h0);
        checkOutput("coldPrefAddr", mem_addr_o, 32'h104);

        applyStimulus(1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h104, 1'b0);
        checkOutput("seqHit104Stall", {31'd0, stall_req_o}, 32'h0);
        checkOutput("seqHit104Data", rom_data_o, memWord(30'h41));
        applyStimulus(1'b1, 32'h104, 1'b1);
        checkOutput("seqPrefAddr108", mem_addr_o, 32'h108);
        applyStimulus(1'b1, 32'h108, 1'b0);
        checkOutput("seqHit108Stall", {31'd0, stall_req_o}, 32'h0);
        checkOutput("seqHit108Data", rom_data_o, memWord(30'h42));
        applyStimulus(1'b1, 32'h108, 1'b0);
        checkOutput("seqConsumedPref", mem_addr_o, 32'h10C);

        cnt = 0;
        applyStimulus(1'b1, 32'h200, 1'b0); cnt += int'(stall_req_o);
        applyStimulus(1'b1, 32'h200, 1'b1); cnt += int'(stall_req_o);
        applyStimulus(1'b1, 32'h200, 1'b0); cnt += int'(stall_req_o);
        checkOutput("branchIdleReq", {31'd0, mem_req_o}, 32'h0);
        applyStimulus(1'b1, 32'h200, 1'b1); cnt += int'(stall_req_o);
        checkOutput("branchDemandAddr", mem_addr_o, 32'h200);
        checkOutput("branchStallCycles", 32'(cnt), 32'd4);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("branchData", rom_data_o, memWord(30'h80));
        applyStimulus(1'b1, 32'h10C, 1'b0);
        checkOutput("branchPrefKept", rom_data_o, memWord(30'h43));
        applyStimulus(1'b1, 32'h10C, 1'b1);

        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        checkOutput("wrapPrefAddr", mem_addr_o, 32'h0000_0000);
        checkOutput("wrapPrefReq", {31'd0, mem_req_o}, 32'h1);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b1, 32'h0000_0000, 1'b0);
        checkOutput("wrapHitData", rom_data_o, memWord(30'h0));

        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0, 1'b0);
            cnt += int'(mem_req_o);
        end
        checkOutput("toReqCycles", 32'(cnt), 32'd4);
        checkOutput("toErrBefore", {31'd0, err_o}, 32'h0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("toReqDrop", {31'd0, mem_req_o}, 32'h0);
        checkOutput("toErrSet", {31'd0, err_o}, 32'h1);
        applyStimulus(1'b1, 32'h0, 1'b1);
        checkOutput("toRetryAddr", mem_addr_o, 32'h4);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("toErrSticky", {31'd0, err_o}, 32'h1);

        applyStimulus(1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b0);
        checkOutput("midDfetchAddr", mem_addr_o, 32'h100);
        pulseReset(32'h100);
        #1;
        checkOutput("postRstMiss", {31'd0, stall_req_o}, 32'h1);
        checkOutput("postRstErrClr", {31'd0, err_o}, 32'h0);
        applyStimulus(1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b0);
        checkOutput("postRstData", rom_data_o, 32'h0050_0093);

        pc = 32'h100;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                case ($urandom_range(0, 4))
                    0:       pc = 32'h100 + (32'($urandom_range(0, 15)) << 2);
                    1:       pc = 32'hFFFF_FFF8;
                    2:       pc = 32'hFFFF_FFFC;
                    3:       pc = 32'h0;
                    default: pc = 32'h4;
                endcase
            end else if (r < 70 && !lastStall) begin
                pc = pc + 32'd4;
            end
            ce  = ($urandom_range(0, 9) != 0);
            ack = ($urandom_range(0, 99) < 65);
            applyStimulus(ce, pc, ack);
            if ($urandom_range(0, 599) == 0) pulseReset(pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles mem_req_o may wait for mem_ack_i.
REQ-002 SHALL have parameter RST_ADDR, default 32'h00000000, informational only; no reset fetch is issued.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rom_ce_i  in  1  CPU fetch enable.
REQ-007 rom_addr_i  in  32  CPU fetch address (pc); bits [1:0] ignored.
REQ-008 rom_data_o  out  32  instruction to CPU.
REQ-009 stall_req_o  out  1  high while the requested word is unavailable.
REQ-010 mem_req_o  out  1  registered memory read request.
REQ-011 mem_addr_o  out  32  registered word address, bits [1:0] = 0.
REQ-012 mem_ack_i  in  1  memory acknowledge; data valid the same cycle.
REQ-013 mem_rdata_i  in  32  memory read data.
REQ-014 err_o  out  1  sticky timeout flag.

Function
REQ-015 SHALL hold two entries: D (demand) and P (prefetch), each with valid, tag = addr[31:2], and 32-bit data.
REQ-016 SHALL set the hit path combinationally with rom_ce_i=1: D hit -> rom_data_o=D.data, stall_req_o=0; else P hit -> rom_data_o=P.data, stall_req_o=0; else stall_req_o=1, rom_data_o=0.
REQ-017 SHALL, with rom_ce_i=0, drive rom_data_o=0 and stall_req_o=0, start no new transfer, and let any in-flight transfer complete.
REQ-018 SHALL, on a P hit, copy P to D and invalidate P at the same edge.
REQ-019 SHALL use FSM states IDLE, DFETCH, PFETCH.
REQ-020 In IDLE with rom_ce_i=1 and a miss: go to DFETCH; mem_req_o=1; mem_addr_o={addr[31:2],2'b00}.
REQ-021 In IDLE with a hit where P does not hold tag+1 (after any REQ-018 update): go to PFETCH; mem_addr_o=(tag+1)<<2.
REQ-022 Prefetch address arithmetic SHALL be 30-bit modulo; 0xFFFFFFFC prefetches 0x00000000.
REQ-023 mem_req_o and mem_addr_o SHALL stay stable until the edge at which mem_ack_i=1.
REQ-024 In DFETCH with ack: write D (valid, tag, mem_rdata_i); then go back-to-back to PFETCH for tag+1 if rom_ce_i=1, else go to IDLE.
REQ-025 In PFETCH with ack: write P.
- If the current rom_addr_i tag equals the fetched tag, write D instead of P.
- Then go to IDLE.
REQ-026 The minimum miss penalty SHALL be 2 stall cycles: a miss at cycle 0, ack in cycle 1, and a hit in cycle 2.
REQ-027 A CPU address change (branch) during DFETCH/PFETCH SHALL NOT abort the transfer; after completion the new address is handled from IDLE.
REQ-028 A counter SHALL increment each cycle mem_req_o=1 and mem_ack_i=0, and clear on ack or on a new request.
- When it reaches TIMEOUT: set err_o=1, drop mem_req_o, leave the entry unwritten, and go to IDLE.
- A still-pending miss is then retried.
REQ-029 err_o SHALL clear only on reset.
REQ-030 If mem_ack_i=1 while mem_req_o=0, it SHALL be ignored.

Reset
REQ-031 While rst=0, SHALL asynchronously force:
- state to IDLE;
- D.valid, P.valid, err_o, mem_req_o, and the timeout counter to 0;
- mem_addr_o to 0.
REQ-032 While rst=0, rom_data_o=0 and stall_req_o=0 regardless of rom_ce_i.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer; after release, the first access is a miss.

Verification
REQ-034 Cold miss:
- Stimulus: release reset, ce=1, addr=0x100, ack one cycle after req with data 0x00500093.
- Response: stall for 3 cycles, then rom_data_o=0x00500093; mem_addr_o then becomes 0x104.
REQ-035 Sequential stream:
- Stimulus: memory acks with zero extra latency; addr steps 0x100, 0x104, 0x108.
- Response: after the first miss, stall_req_o=0 on every P-hit cycle and P is consumed each time.
REQ-036 Branch during prefetch:
- Stimulus: PFETCH for 0x104 in flight; addr jumps to 0x200.
- Response: 0x104 is written to P, then DFETCH for 0x200 runs; stall holds until 0x200's data returns.
REQ-037 Wrap:
- Stimulus: hit on 0xFFFFFFFC.
- Response: mem_addr_o=0x00000000 in PFETCH.
REQ-038 Timeout:
- Stimulus: TIMEOUT=4, mem_ack_i held 0.
- Response: after 4 request cycles, mem_req_o drops for 1 cycle and err_o=1.
- Follow-up: the request is retried; err_o stays 1 after a later ack.
REQ-039 Async reset:
- Stimulus: assert rst=0 mid-DFETCH, between clock edges.
- Response: mem_req_o=0 immediately; after release, 0x100 misses again.
